strobe_sequencer: RTL and testbench

STROBE_SEQUENCER -- requirements
Module: strobe_sequencer

---
 rtl/strobe_pkg.sv | 26 ++
 rtl/tick_div.sv | 38 +++
 rtl/strobe_sequencer.sv | 123 ++++++++++++
 tb/tb_strobe_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/strobe_pkg.sv
// Shared definitions for the strobe sequencer and its tick prescaler:
// FSM encoding, prescaler ratio and counter widths.
package strobe_pkg;

   localparam int TICK_DIV = 24;
   localparam int CNT_W    = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FIRE = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Burst configuration captured at start so later register writes cannot disturb it.
   typedef struct packed {
      logic [CNT_W-1:0] countbase;
      logic [CNT_W-1:0] strbcount;
   } shadow_t;

   function automatic logic burst_complete(input logic [CNT_W-1:0] strbcount,
                                           input logic [CNT_W-1:0] index);
      return (strbcount != '0) && (index == strbcount);
   endfunction

endpackage

// File: rtl/tick_div.sv
// Divide-by-DIV prescaler producing a one-cycle tick on the last phase.
// clr forces phase 0 on the following cycle.
module tick_div
   import strobe_pkg::*;
#(
   parameter int DIV = TICK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt_q, cnt_d;

   // NOTE: combinational blocks assign every output a default first so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q + W'(1);
      if (clr || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/strobe_sequencer.sv
// Burst sequencer issuing single-strobe triggers every 24*COUNTBASE clocks.
// All outputs are registered from the next-state decode.
module strobe_sequencer
   import strobe_pkg::*;
(
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] FPGA_COUNTBASE,
   input  logic [CNT_W-1:0] FPGA_STRBCOUNT,
   input  logic [CNT_W-1:0] FPGA_LAMPENABLE,
   output logic             flag_en_single_strobe,
   output logic             busy,
   output logic             strobe_done,
   output logic             cfg_err,
   output logic [CNT_W-1:0] strobe_index
);

   state_e           state_q, state_d;
   shadow_t          shadow_q, shadow_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] index_q, index_d;
   logic             cfg_err_d;
   logic             flag_q, busy_q, done_q, cfg_err_q;
   logic             tick;
   logic             lamp_on;
   logic             unused_lamp_bits;

   assign lamp_on          = FPGA_LAMPENABLE[0];
   assign unused_lamp_bits = ^FPGA_LAMPENABLE[CNT_W-1:1];

   // Clearing on entry to FIRE makes the FIRE cycle prescaler phase 0.
   tick_div #(
      .DIV (TICK_DIV)
   ) u_tick_div (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .clr   (state_d == ST_FIRE),
      .tick  (tick)
   );

   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      period_d  = period_q;
      index_d   = index_q;
      cfg_err_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               if (FPGA_COUNTBASE == '0) begin
                  cfg_err_d = 1'b1;
               end else if (lamp_on) begin
                  shadow_d = '{countbase: FPGA_COUNTBASE, strbcount: FPGA_STRBCOUNT};
                  index_d  = '0;
                  state_d  = ST_FIRE;
               end
            end
         end
         ST_FIRE: begin
            period_d = '0;
            state_d  = burst_complete(shadow_q.strbcount, index_q) ? ST_DONE : ST_WAIT;
         end
         ST_WAIT: begin
            // The COUNTBASE-th tick is the last phase before the next FIRE.
            if (tick) begin
               if ((period_q + CNT_W'(1)) == shadow_q.countbase) begin
                  state_d = ST_FIRE;
               end else begin
                  period_d = period_q + CNT_W'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if ((state_q != ST_IDLE) && (abort || !lamp_on)) begin
         state_d = ST_IDLE;
      end

      // The index advances on entry to FIRE so it is visible alongside the flag.
      if (state_d == ST_FIRE) begin
         index_d = index_d + CNT_W'(1);
      end
   end

   // NOTE: shadow and counter registers are reset too, so a burst never starts from stale config.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= ST_IDLE;
         shadow_q  <= '0;
         period_q  <= '0;
         index_q   <= '0;
         flag_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         period_q  <= period_d;
         index_q   <= index_d;
         flag_q    <= (state_d == ST_FIRE);
         busy_q    <= (state_d != ST_IDLE);
         done_q    <= (state_d == ST_DONE);
         cfg_err_q <= cfg_err_d;
      end
   end

   assign flag_en_single_strobe = flag_q;
   assign busy                  = busy_q;
   assign strobe_done           = done_q;
   assign cfg_err               = cfg_err_q;
   assign strobe_index          = index_q;

endmodule

// File: tb/tb_strobe_sequencer.sv
// Directed bench for strobe_sequencer: per-cycle vector table plus
// multi-cycle burst, abort, lamp-drop, config-change and reset sequences.
module tb_strobe_sequencer;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        start, abort;
   logic [15:0] cb, sc;
   logic        lamp;
   logic        flag, busy, done, cfg;
   logic [15:0] idx;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   int flag_at[$];
   int done_at[$];
   int idx_at_flag[$];
   int busy_cnt;

   typedef struct {
      logic        start;
      logic        abort;
      logic        lamp;
      logic [15:0] cb;
      logic [15:0] sc;
      logic        flag;
      logic        busy;
      logic        done;
      logic        cfg;
      logic [15:0] idx;
   } vec_t;

   vec_t tbl[11];

   strobe_sequencer dut (
      .sys_clk               (sys_clk),
      .sys_rst_n             (sys_rst_n),
      .start                 (start),
      .abort                 (abort),
      .FPGA_COUNTBASE        (cb),
      .FPGA_STRBCOUNT        (sc),
      .FPGA_LAMPENABLE       ({15'h2AAA, lamp}),
      .flag_en_single_strobe (flag),
      .busy                  (busy),
      .strobe_done           (done),
      .cfg_err               (cfg),
      .strobe_index          (idx)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required=<2ms", $time);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   function automatic int qget(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   // Caller raises start; k=1 is the cycle after start is sampled.
   task automatic observe(input int n, input bit do_change,
                          input logic [15:0] new_cb, input logic [15:0] new_sc);
      flag_at.delete();
      done_at.delete();
      idx_at_flag.delete();
      busy_cnt = 0;
      for (int k = 1; k <= n; k++) begin
         step();
         if (k == 1) begin
            start = 1'b0;
            if (do_change) begin
               cb = new_cb;
               sc = new_sc;
            end
         end
         if (flag) begin
            flag_at.push_back(k);
            idx_at_flag.push_back(int'(idx));
         end
         if (done) done_at.push_back(k);
         if (busy) busy_cnt++;
      end
   endtask

   initial begin
      int   nflag;
      int   ndone;
      int   abort_k;
      int   activity;

      tbl[0]  = '{1'b1, 1'b0, 1'b1, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 16'd3, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'd3, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
      tbl[4]  = '{1'b1, 1'b0, 1'b1, 16'd1, 16'd1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 16'd1, 16'd1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 16'd1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
      tbl[7]  = '{1'b1, 1'b0, 1'b1, 16'd1, 16'd2, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 16'd1, 16'd2, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 16'd1, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 16'd1, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};

      sys_rst_n = 1'b0;
      start = 1'b0; abort = 1'b0; lamp = 1'b1; cb = 16'd0; sc = 16'd0;
      step(); step();
      check("reset_outputs", {11'd0, flag, busy, done, cfg, idx}, 32'd0);
      sys_rst_n = 1'b1;
      activity = 0;
      for (int k = 0; k < 30; k++) begin
         step();
         if (flag || busy || done) activity++;
      end
      check("post_reset_idle", activity, 0);

      // Per-cycle vector table
      for (int i = 0; i < 11; i++) begin
         start = tbl[i].start; abort = tbl[i].abort; lamp = tbl[i].lamp;
         cb = tbl[i].cb; sc = tbl[i].sc;
         step();
         check($sformatf("vec%0d", i), {11'd0, flag, busy, done, cfg, idx},
               {11'd0, tbl[i].flag, tbl[i].busy, tbl[i].done, tbl[i].cfg, tbl[i].idx});
      end
      start = 1'b0; abort = 1'b0;

      // Finite burst COUNTBASE=2, STRBCOUNT=3
      cb = 16'd2; sc = 16'd3; start = 1'b1;
      observe(110, 1'b0, 16'd0, 16'd0);
      check("b3_nflags", flag_at.size(), 3);
      check("b3_flag0", qget(flag_at, 0), 1);
      check("b3_flag1", qget(flag_at, 1), 49);
      check("b3_flag2", qget(flag_at, 2), 97);
      check("b3_ndone", done_at.size(), 1);
      check("b3_done_at", qget(done_at, 0), 98);
      check("b3_busy_cycles", busy_cnt, 98);
      check("b3_index", idx, 3);

      // COUNTBASE/STRBCOUNT changed mid-burst: shadow values must rule
      cb = 16'd2; sc = 16'd3; start = 1'b1;
      observe(130, 1'b1, 16'd5, 16'd1);
      check("chg_nflags", flag_at.size(), 3);
      check("chg_flag1", qget(flag_at, 1), 49);
      check("chg_flag2", qget(flag_at, 2), 97);
      check("chg_done_at", qget(done_at, 0), 98);

      // Continuous mode, abort after the 5th flag
      cb = 16'd1; sc = 16'd0; start = 1'b1;
      flag_at.delete();
      ndone = 0; abort_k = 0;
      for (int k = 1; k <= 160; k++) begin
         step();
         start = 1'b0;
         abort = 1'b0;
         if (flag) flag_at.push_back(k);
         if (done) ndone++;
         if (abort_k != 0 && k == abort_k + 1)
            check("abort_idle", {busy, flag, done}, 3'b000);
         if (flag_at.size() == 5 && abort_k == 0) begin
            abort   = 1'b1;
            abort_k = k;
         end
      end
      check("abort_nflags", flag_at.size(), 5);
      for (int i = 1; i < 5; i++)
         check($sformatf("abort_gap%0d", i), qget(flag_at, i) - qget(flag_at, i - 1), 24);
      check("abort_ndone", ndone, 0);
      check("abort_index", idx, 5);

      // Lamp enable dropped mid-WAIT, then a fresh burst
      cb = 16'd2; sc = 16'd0; start = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step();
         start = 1'b0;
      end
      lamp = 1'b0;
      step();
      check("lamp_drop", {busy, flag, done}, 3'b000);
      activity = 0;
      for (int k = 0; k < 60; k++) begin
         step();
         if (flag || busy || done) activity++;
      end
      check("lamp_quiet", activity, 0);
      check("lamp_index_hold", idx, 1);
      lamp = 1'b1; cb = 16'd1; sc = 16'd2; start = 1'b1;
      observe(40, 1'b0, 16'd0, 16'd0);
      check("relamp_first_idx", qget(idx_at_flag, 0), 1);
      check("relamp_second_idx", qget(idx_at_flag, 1), 2);
      check("relamp_flag1", qget(flag_at, 1), 25);
      check("relamp_done_at", qget(done_at, 0), 26);

      // Asynchronous reset mid-WAIT
      cb = 16'd2; sc = 16'd0; start = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step();
         start = 1'b0;
      end
      check("prerst_busy", {busy, idx}, {1'b1, 16'd1});
      #2;
      sys_rst_n = 1'b0;
      #1;
      check("async_rst", {11'd0, flag, busy, done, cfg, idx}, 32'd0);
      @(posedge sys_clk);
      @(posedge sys_clk);
      #5;
      sys_rst_n = 1'b1;
      activity = 0;
      for (int k = 0; k < 60; k++) begin
         step();
         if (flag || busy || done || cfg) activity++;
      end
      check("rst_quiet", activity, 0);
      cb = 16'd1; sc = 16'd1; start = 1'b1;
      observe(5, 1'b0, 16'd0, 16'd0);
      check("rst_new_flag", qget(flag_at, 0), 1);
      check("rst_new_done", qget(done_at, 0), 2);
      check("rst_new_idx", idx, 1);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
